swan64k256_dec_iter: RTL and testbench

SWAN64K256_DEC_ITER -- requirements
Module: swan64k256_dec_iter

---
 rtl/swan64_pkg.sv | 28 ++
 rtl/swan64k256_key_fwd_step.sv | 18 +
 rtl/swan64k256_round_parts.sv | 50 +++++
 rtl/swan64k256_dec_iter.sv | 121 ++++++++++++
 tb/tb_swan64k256_dec_iter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/swan64_pkg.sv
// Shared constants, FSM encoding and nibble S-box for the SWAN64/256 iterative decryptor.
package swan64_pkg;
  localparam int BLOCK_SIZE  = 64;
  localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int KEY_SIZE    = 256;
  localparam int HALF_ROUNDS = 128;
  localparam int PD          = 24;
  localparam logic [31:0] DELTA0 = 32'h9e3779b9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REWIND = 2'd2,
    ROUND  = 2'd3
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] v);
    logic [3:0] s;
    case (v)
      4'h0: s = 4'hc;  4'h1: s = 4'h5;  4'h2: s = 4'h6;  4'h3: s = 4'hb;
      4'h4: s = 4'h9;  4'h5: s = 4'h0;  4'h6: s = 4'ha;  4'h7: s = 4'hd;
      4'h8: s = 4'h3;  4'h9: s = 4'he;  4'ha: s = 4'hf;  4'hb: s = 4'h8;
      4'hc: s = 4'h4;  4'hd: s = 4'h7;  4'he: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/swan64k256_key_fwd_step.sv
// One forward key-schedule step, used to rewind the master key before decryption.
module swan64k256_key_fwd_step
  import swan64_pkg::*;
#(
  parameter int          ROT   = PD,
  parameter logic [31:0] DELTA = DELTA0
) (
  input  logic [0:KEY_SIZE-1]  key,
  input  logic [SIDE_SIZE-1:0] rd,
  output logic [0:KEY_SIZE-1]  next_key,
  output logic [SIDE_SIZE-1:0] next_rd
);
  logic [0:KEY_SIZE-1] rot;

  assign next_rd  = rd + DELTA;
  assign rot      = {key[KEY_SIZE-ROT:KEY_SIZE-1], key[0:KEY_SIZE-1-ROT]};
  assign next_key = {rot[0:KEY_SIZE-33], rot[KEY_SIZE-32:KEY_SIZE-1] + next_rd};
endmodule

// File: rtl/swan64k256_round_parts.sv
// Round-function building blocks and the reverse key schedule step.
module vartheta
  import swan64_pkg::*;
(
  input  logic [SIDE_SIZE-1:0] din,
  output logic [SIDE_SIZE-1:0] dout
);
  assign dout = din ^ {din[24:0], din[31:25]} ^ {din[13:0], din[31:14]};
endmodule

module beta_table
  import swan64_pkg::*;
(
  input  logic [SIDE_SIZE-1:0] din,
  output logic [SIDE_SIZE-1:0] dout
);
  for (genvar gi = 0; gi < SIDE_SIZE / 4; gi++) begin : g_nib
    assign dout[4*gi +: 4] = sbox4(din[4*gi +: 4]);
  end
endmodule

module rho
  import swan64_pkg::*;
(
  input  logic [SIDE_SIZE-1:0] din,
  output logic [SIDE_SIZE-1:0] dout
);
  assign dout = {din[28:0], din[31:29]};
endmodule

module dec_key_schedule_256
  import swan64_pkg::*;
#(
  parameter int          ROT   = PD,
  parameter logic [31:0] DELTA = DELTA0
) (
  input  logic [0:KEY_SIZE-1]  key,
  input  logic [SIDE_SIZE-1:0] rd,
  output logic [SIDE_SIZE-1:0] sk,
  output logic [0:KEY_SIZE-1]  next_key,
  output logic [SIDE_SIZE-1:0] next_rd
);
  logic [0:KEY_SIZE-1] unmix;

  // Undo one forward step: remove rd from the low word, then rotate left.
  assign sk       = key[KEY_SIZE-32:KEY_SIZE-1];
  assign unmix    = {key[0:KEY_SIZE-33], key[KEY_SIZE-32:KEY_SIZE-1] - rd};
  assign next_key = {unmix[ROT:KEY_SIZE-1], unmix[0:ROT-1]};
  assign next_rd  = rd - DELTA;
endmodule

// File: rtl/swan64k256_dec_iter.sv
// Iterative SWAN64/256 decryptor: 128-step key rewind, then one half-round per clock.
module swan64k256_dec_iter #(
  parameter int          BLOCK_SIZE  = swan64_pkg::BLOCK_SIZE,
  parameter int          KEY_SIZE    = swan64_pkg::KEY_SIZE,
  parameter int          HALF_ROUNDS = swan64_pkg::HALF_ROUNDS,
  parameter int          PD          = swan64_pkg::PD,
  parameter logic [31:0] DELTA0      = swan64_pkg::DELTA0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [0:BLOCK_SIZE-1] inp,
  input  logic [0:KEY_SIZE-1]   key,
  output logic                  busy,
  output logic                  ready,
  output logic [0:BLOCK_SIZE-1] out
);
  localparam int SW = swan64_pkg::SIDE_SIZE;
  localparam logic [6:0] CNT_LAST = 7'(HALF_ROUNDS - 1);

  swan64_pkg::state_t state_reg, state_next;
  logic [6:0]          cnt_reg, cnt_next;
  logic [SW-1:0]       l_reg, l_next, r_reg, r_next;
  logic [SW-1:0]       rd_reg, rd_next;
  logic [0:KEY_SIZE-1] key_reg, key_next;
  logic                busy_reg, busy_next, ready_reg, ready_next;

  logic [0:KEY_SIZE-1] fwd_key, dec_key;
  logic [SW-1:0]       fwd_rd, dec_rd, sk, x, vt0, bt, vt1, f;

  swan64k256_key_fwd_step #(.ROT(PD), .DELTA(DELTA0)) u_fwd (
    .key(key_reg), .rd(rd_reg), .next_key(fwd_key), .next_rd(fwd_rd)
  );

  dec_key_schedule_256 #(.ROT(PD), .DELTA(DELTA0)) u_dec (
    .key(key_reg), .rd(rd_reg), .sk(sk), .next_key(dec_key), .next_rd(dec_rd)
  );

  // Odd counts consume R and update L; even counts the reverse.
  assign x = cnt_reg[0] ? r_reg : l_reg;

  vartheta   u_vt0  (.din(x),        .dout(vt0));
  beta_table u_beta (.din(vt0 ^ sk), .dout(bt));
  vartheta   u_vt1  (.din(bt),       .dout(vt1));
  rho        u_rho  (.din(vt1),      .dout(f));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= swan64_pkg::IDLE;
      cnt_reg   <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      rd_reg    <= '0;
      key_reg   <= '0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      l_reg     <= l_next;
      r_reg     <= r_next;
      rd_reg    <= rd_next;
      key_reg   <= key_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    l_next     = l_reg;
    r_next     = r_reg;
    rd_next    = rd_reg;
    key_next   = key_reg;
    busy_next  = busy_reg;
    ready_next = ready_reg;
    if (start) begin
      state_next = swan64_pkg::REWIND;
      cnt_next   = CNT_LAST;
      r_next     = inp[0:SW-1];
      l_next     = inp[SW:BLOCK_SIZE-1];
      key_next   = key;
      rd_next    = '0;
      busy_next  = 1'b1;
      ready_next = 1'b0;
    end else begin
      case (state_reg)
        swan64_pkg::REWIND: begin
          key_next = fwd_key;
          rd_next  = fwd_rd;
          if (cnt_reg == 7'd0) begin
            cnt_next   = CNT_LAST;
            state_next = swan64_pkg::ROUND;
          end else begin
            cnt_next = cnt_reg - 7'd1;
          end
        end
        swan64_pkg::ROUND: begin
          key_next = dec_key;
          rd_next  = dec_rd;
          if (cnt_reg[0]) l_next = l_reg ^ f;
          else            r_next = r_reg ^ f;
          if (cnt_reg == 7'd0) begin
            state_next = swan64_pkg::IDLE;
            busy_next  = 1'b0;
            ready_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - 7'd1;
          end
        end
        swan64_pkg::LOAD: state_next = swan64_pkg::REWIND;
        default: ;
      endcase
    end
  end

  assign busy  = busy_reg;
  assign ready = ready_reg;
  assign out   = {r_reg, l_reg};
endmodule

// File: tb/tb_swan64k256_dec_iter.sv
// Directed bench: ciphertexts come from a forward SWAN64/256 model; decryption must restore the plaintext.
module tb_swan64k256_dec_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [0:63]  inp = '0;
  logic [0:255] key = '0;
  logic        busy, ready;
  logic [0:63]  out;

  int tests = 0;
  int fails = 0;

  logic [3:0] sbox_tab [16] = '{4'hc, 4'h5, 4'h6, 4'hb, 4'h9, 4'h0, 4'ha, 4'hd,
                                4'h3, 4'he, 4'hf, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  swan64k256_dec_iter dut (
    .clk(clk), .rst(rst), .start(start), .inp(inp), .key(key),
    .busy(busy), .ready(ready), .out(out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] mixf(input logic [31:0] xin, input logic [31:0] sk);
    logic [31:0] a, b;
    a = xin ^ rotl32(xin, 7) ^ rotl32(xin, 18);
    a = a ^ sk;
    for (int n = 0; n < 8; n++) b[4*n +: 4] = sbox_tab[a[4*n +: 4]];
    a = b ^ rotl32(b, 7) ^ rotl32(b, 18);
    return rotl32(a, 3);
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [255:0] k0);
    logic [255:0] k;
    logic [31:0]  rd, r, l;
    k  = k0;
    rd = 32'h0;
    r  = pt[63:32];
    l  = pt[31:0];
    for (int i = 0; i < 128; i++) begin
      rd = rd + 32'h9e3779b9;
      k  = (k >> 24) | (k << 232);
      k[31:0] = k[31:0] + rd;
      if (i % 2 == 0) r = r ^ mixf(l, k[31:0]);
      else            l = l ^ mixf(r, k[31:0]);
    end
    return {r, l};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [63:0] ct, input logic [255:0] k,
                         output int lat, output int bcnt);
    inp = ct;
    key = k;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!ready && lat < 400) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 = {256{1'b1}};
  localparam logic [255:0] K3 = 256'hdeadbeef_0badf00d_12345678_9abcdef0_cafebabe_55aa55aa_0f0f0f0f_76543210;
  localparam logic [63:0]  P1 = 64'h0123456789abcdef;
  localparam logic [63:0]  P2 = 64'h0;
  localparam logic [63:0]  P3 = 64'hfedcba9876543210;

  initial begin
    logic [63:0] c1, c2, c3;
    int lat, bcnt;
    bit stable;
    c1 = encrypt(P1, K1);
    c2 = encrypt(P2, K2);
    c3 = encrypt(P3, K3);

    // Reset state and quiet idle after release
    repeat (3) step();
    check("rst_out", out, 64'h0);
    check("rst_ready", ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (3) step();
    check("idle_out", out, 64'h0);
    check("idle_busy", busy, 1'b0);

    // Round trip with the byte-sequence key
    run_job(c1, K1, lat, bcnt);
    check("job1_latency", lat, 256);
    check("job1_out", out, P1);
    check("job1_busy_cycles", bcnt, 256);
    check("job1_busy_end", busy, 1'b0);
    $display("[TB] job1 ct=%h out=%h lat=%0d", c1, out, lat);

    // Idle hold with ready high
    stable = 1'b1;
    repeat (50) begin
      step();
      if (out !== P1 || ready !== 1'b1 || busy !== 1'b0) stable = 1'b0;
    end
    check("hold50_stable", stable, 1'b1);
    check("hold50_out", out, P1);

    // All-ones key, zero plaintext
    run_job(c2, K2, lat, bcnt);
    check("job2_latency", lat, 256);
    check("job2_out", out, P2);
    check("job2_busy_cycles", bcnt, 256);
    $display("[TB] job2 ct=%h out=%h lat=%0d", c2, out, lat);

    // Reset pulse 100 edges into a job
    inp = c1;
    key = K1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (100) step();
    check("mid_busy", busy, 1'b1);
    check("mid_out_rewind", out, c1);
    rst = 1'b0;
    #1;
    check("arst_out", out, 64'h0);
    check("arst_ready", ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_idle", busy, 1'b0);
    run_job(c1, K1, lat, bcnt);
    check("job_after_rst_latency", lat, 256);
    check("job_after_rst_out", out, P1);
    $display("[TB] job after reset out=%h lat=%0d", out, lat);

    // Restart at edge 200 discards the first job
    inp = c2;
    key = K2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (199) step();
    check("pre_restart_ready", ready, 1'b0);
    run_job(c3, K3, lat, bcnt);
    check("restart_latency", lat, 256);
    check("restart_out", out, P3);
    $display("[TB] restart out=%h lat=%0d", out, lat);

    // Start held for 5 cycles
    inp = c1;
    key = K1;
    start = 1'b1;
    stable = 1'b1;
    repeat (4) begin
      step();
      if (busy !== 1'b1 || ready !== 1'b0) stable = 1'b0;
    end
    check("held_busy_ready", stable, 1'b1);
    run_job(c1, K1, lat, bcnt);
    check("held_latency", lat, 256);
    check("held_out", out, P1);
    $display("[TB] held start out=%h lat=%0d", out, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
